// File: rtl/regfile_pkg.sv
// Shared types and helpers for the multi-port register file.
// Index extraction drops the byte offset and keeps the low index bits.
package regfile_pkg;

    localparam int RF_MAX_RD = 4;

    typedef enum logic [1:0] {
        RF_CLEAR = 2'd0,
        RF_LOAD  = 2'd1,
        RF_RUN   = 2'd2
    } rf_state_t;

    // Higher address bits are masked off, so out-of-range addresses alias.
    function automatic logic [31:0] rf_index(input logic [31:0] byte_addr, input int addr_w);
        return (byte_addr >> 2) & ((32'd1 << addr_w) - 32'd1);
    endfunction

endpackage

// File: rtl/regfile_bank.sv
// One storage copy with a shared write port and one registered read port.
// REGFILE_BYPASS_EN selects write-first behaviour on a same-index read/write.
module regfile_bank
    import regfile_pkg::*;
#(
    parameter int DATA_W   = 32,
    parameter int ADDR_W   = 5,
    parameter int ZERO_REG = 1
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] wr_idx,
    input  logic [DATA_W-1:0] wr_data,
    input  logic              rd_en,
    input  logic              rd_clr,
    input  logic [ADDR_W-1:0] rd_idx,
    output logic [DATA_W-1:0] rd_data
);

    localparam int DEPTH = 1 << ADDR_W;

    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [DATA_W-1:0] rd_data_q, rd_data_d;
    logic [DATA_W-1:0] rd_word;
    logic              fwd_hit;

`ifdef REGFILE_BYPASS_EN
    assign fwd_hit = wr_en && (wr_idx == rd_idx);
`else
    assign fwd_hit = 1'b0;
`endif

    // NOTE: every variable gets a default at the top of always_comb so no path can infer a latch.
    always_comb begin
        rd_word = fwd_hit ? wr_data : mem_q[rd_idx];
        if ((ZERO_REG != 0) && (rd_idx == '0)) begin
            rd_word = '0;
        end
        rd_data_d = rd_data_q;
        if (rd_clr) begin
            rd_data_d = '0;
        end else if (rd_en) begin
            rd_data_d = rd_word;
        end
    end

    // NOTE: the array has no reset; the clear sequence zeroes it, which keeps it mappable to RAM.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem_q[wr_idx] <= wr_data;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so all flops update together.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rd_data_q <= '0;
        end else begin
            rd_data_q <= rd_data_d;
        end
    end

    assign rd_data = rd_data_q;

endmodule

// File: rtl/register_file_mp.sv
// Multi-read-port register file: clear sequencer, loader/CPU port muxing.
// Optional write-first forwarding is enabled by defining REGFILE_BYPASS_EN.
module register_file_mp
    import regfile_pkg::*;
#(
    parameter int DATA_W   = 32,
    parameter int ADDR_W   = 5,
    parameter int N_RD     = 2,
    parameter int ZERO_REG = 1
) (
    input  logic                   clk,
    input  logic                   reset_n,
    input  logic                   alive,
    input  logic                   clr,
    output logic                   busy,
    input  logic [1:0]             cpu_clk_en,
    input  logic [N_RD*32-1:0]     cpu_rd_addr,
    output logic [N_RD*DATA_W-1:0] cpu_rd_data,
    input  logic [31:0]            cpu_wr_addr,
    input  logic [DATA_W-1:0]      cpu_wr_data,
    input  logic                   cpu_wren,
    input  logic                   mau_clk_en,
    input  logic [31:0]            mau_addr,
    input  logic [DATA_W-1:0]      mau_wr_data,
    input  logic                   mau_wren
);

    rf_state_t         state_q, state_d;
    logic [ADDR_W-1:0] cnt_q, cnt_d;

    logic              wr_en;
    logic              ext_wr;
    logic [ADDR_W-1:0] wr_idx;
    logic [DATA_W-1:0] wr_data;
    logic              rd_en;
    logic              rd_clr;
    logic [ADDR_W-1:0] rd_idx [N_RD];

    // The mode is chosen from `alive` only once the clear has visited every entry.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            RF_CLEAR: begin
                if (clr) begin
                    cnt_d = '0;
                end else begin
                    cnt_d = cnt_q + ADDR_W'(1);
                    if (&cnt_q) begin
                        state_d = alive ? RF_RUN : RF_LOAD;
                    end
                end
            end
            default: begin
                if (clr) begin
                    state_d = RF_CLEAR;
                    cnt_d   = '0;
                end else begin
                    state_d = alive ? RF_RUN : RF_LOAD;
                end
            end
        endcase
    end

    always_comb begin
        wr_en   = 1'b0;
        ext_wr  = 1'b0;
        wr_idx  = cnt_q;
        wr_data = '0;
        rd_en   = 1'b0;
        rd_clr  = 1'b0;
        for (int p = 0; p < N_RD; p++) begin
            rd_idx[p] = ADDR_W'(rf_index(cpu_rd_addr[p*32 +: 32], ADDR_W));
        end
        case (state_q)
            RF_CLEAR: begin
                wr_en  = 1'b1;
                rd_clr = 1'b1;
            end
            RF_LOAD: begin
                rd_en     = mau_clk_en;
                ext_wr    = mau_wren & mau_clk_en;
                wr_idx    = ADDR_W'(rf_index(mau_addr, ADDR_W));
                wr_data   = mau_wr_data;
                rd_idx[0] = wr_idx;
            end
            RF_RUN: begin
                rd_en   = |cpu_clk_en;
                ext_wr  = cpu_wren & cpu_clk_en[1];
                wr_idx  = ADDR_W'(rf_index(cpu_wr_addr, ADDR_W));
                wr_data = cpu_wr_data;
            end
            default: begin
                rd_clr = 1'b1;
            end
        endcase
        // A clear request drops the coincident write; the hardwired zero entry drops all writes.
        if (ext_wr && !clr && !((ZERO_REG != 0) && (wr_idx == '0))) begin
            wr_en = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= RF_CLEAR;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    assign busy = (state_q == RF_CLEAR);

    for (genvar p = 0; p < N_RD; p++) begin : g_bank
        regfile_bank #(
            .DATA_W  (DATA_W),
            .ADDR_W  (ADDR_W),
            .ZERO_REG(ZERO_REG)
        ) u_bank (
            .clk    (clk),
            .reset_n(reset_n),
            .wr_en  (wr_en),
            .wr_idx (wr_idx),
            .wr_data(wr_data),
            .rd_en  (rd_en),
            .rd_clr (rd_clr),
            .rd_idx (rd_idx[p]),
            .rd_data(cpu_rd_data[p*DATA_W +: DATA_W])
        );
    end

endmodule
